// File: rtl/falco_pkg.sv
// Shared integer-core parameters and types for the issue-queue blocks.
package falco_pkg;

    // Integer issue-queue geometry defaults.
    localparam int INT_IQ_SIZE     = 8;
    localparam int INT_ISSUE_WIDTH = 2;
    localparam int DISPATCH_WIDTH  = 2;
    localparam int INT_IQ_IDX_W    = $clog2(INT_IQ_SIZE);

    typedef logic [INT_IQ_IDX_W-1:0] int_iq_idx_t;

    // Bits needed to hold a population count of n flags (0..n inclusive).
    function automatic int rank_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/age_rank_popcount.sv
// One age-matrix row reduced to a rank: how many current candidates are
// older than this slot.
module age_rank_popcount
    import falco_pkg::*;
#(
    parameter int N_ENTRY = INT_IQ_SIZE,
    parameter int CNT_W   = rank_width(N_ENTRY)
) (
    input  logic [N_ENTRY-1:0] row,
    input  logic [N_ENTRY-1:0] mask,
    output logic [CNT_W-1:0]   count
);

    // Masked population count of the row.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so the running sum is
        // read back within the same evaluation; sequential blocks use '<='.
        count = '0;
        for (int j = 0; j < N_ENTRY; j++) begin
            count = count + CNT_W'(row[j] & mask[j]);
        end
    end

endmodule

// File: rtl/int_age_matrix_picker.sv
// Oldest-first picker for the integer issue queue. Relative age lives in an
// N_ENTRY x N_ENTRY matrix; older[i][j]=1 means slot j is older than slot i.
// Each candidate's rank is the number of older candidates, and grant slot s
// takes the candidate whose rank equals s, so grants come out oldest-first
// and compacted. Grants are registered and retire their slots on load.
module int_age_matrix_picker
    import falco_pkg::*;
#(
    parameter int N_ENTRY = INT_IQ_SIZE,
    parameter int ISSUE_W = INT_ISSUE_WIDTH,
    parameter int ALLOC_W = DISPATCH_WIDTH,
    parameter int IDX_W   = $clog2(N_ENTRY)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [ALLOC_W-1:0]              alloc_valid,
    input  logic [ALLOC_W-1:0][IDX_W-1:0]   alloc_idx,
    input  logic [N_ENTRY-1:0]              req_ready,
    input  logic                            issue_stall,
    output logic [ISSUE_W-1:0]              grant_valid,
    output logic [ISSUE_W-1:0][IDX_W-1:0]   grant_idx
);

    localparam int CNT_W = rank_width(N_ENTRY);

    // Age-tracking state.
    logic [N_ENTRY-1:0]              valid;
    logic [N_ENTRY-1:0]              valid_next;
    logic [N_ENTRY-1:0][N_ENTRY-1:0] older;
    logic [N_ENTRY-1:0][N_ENTRY-1:0] older_next;

    // Select datapath.
    logic [N_ENTRY-1:0]              cand;
    logic [N_ENTRY-1:0][CNT_W-1:0]   rank;
    logic [ISSUE_W-1:0][N_ENTRY-1:0] sel;
    logic [N_ENTRY-1:0]              picked;
    logic [ISSUE_W-1:0]              grant_valid_next;
    logic [ISSUE_W-1:0][IDX_W-1:0]   grant_idx_next;

    // Allocation decode.
    logic [ALLOC_W-1:0][N_ENTRY-1:0] alloc_onehot;
    logic [N_ENTRY-1:0]              alloc_any;
    logic [N_ENTRY-1:0]              alloc_prior;

    // Slots allocated this cycle are not yet valid, so they cannot be candidates.
    assign cand = valid & req_ready;

    // Per-row rank: number of candidates older than slot i.
    for (genvar i = 0; i < N_ENTRY; i++) begin : g_rank
        age_rank_popcount #(
            .N_ENTRY (N_ENTRY),
            .CNT_W   (CNT_W)
        ) u_rank (
            .row   (older[i]),
            .mask  (cand),
            .count (rank[i])
        );
    end

    // Decode each allocation lane into a one-hot slot mask.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned and no latch is inferred.
        alloc_onehot = '0;
        alloc_any    = '0;
        for (int k = 0; k < ALLOC_W; k++) begin
            if (alloc_valid[k]) begin
                alloc_onehot[k] = N_ENTRY'(1) << alloc_idx[k];
            end
            alloc_any = alloc_any | alloc_onehot[k];
        end
    end

    // Rank-to-slot one-hot select and index encode for each grant slot.
    always_comb begin
        sel              = '0;
        picked           = '0;
        grant_valid_next = '0;
        grant_idx_next   = '0;
        for (int s = 0; s < ISSUE_W; s++) begin
            for (int i = 0; i < N_ENTRY; i++) begin
                if (cand[i] && (rank[i] == CNT_W'(s))) begin
                    sel[s][i] = 1'b1;
                end
            end
            grant_valid_next[s] = |sel[s];
            for (int i = 0; i < N_ENTRY; i++) begin
                if (sel[s][i]) begin
                    grant_idx_next[s] = grant_idx_next[s] | IDX_W'(i);
                end
            end
            picked = picked | sel[s];
        end
    end

    // Next valid vector and age matrix: flush, then select retire, then alloc.
    always_comb begin
        valid_next  = valid;
        older_next  = older;
        alloc_prior = '0;
        if (flush) begin
            // The matrix is left alone; stale bits are masked by valid.
            valid_next = '0;
        end else begin
            if (!issue_stall) begin
                valid_next = valid_next & ~picked;
            end
            // Clear the columns of newly allocated slots first, so the row
            // writes below keep a younger lane's view of older same-cycle lanes.
            for (int j = 0; j < N_ENTRY; j++) begin
                older_next[j] = older_next[j] & ~alloc_any;
            end
            for (int k = 0; k < ALLOC_W; k++) begin
                if (alloc_valid[k]) begin
                    older_next[alloc_idx[k]] = valid | alloc_prior;
                    valid_next[alloc_idx[k]] = 1'b1;
                end
                alloc_prior = alloc_prior | alloc_onehot[k];
            end
        end
    end

    // Age state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            // NOTE: the age matrix is a flop array, not a RAM, so it takes the
            // async reset like any other state and starts from a known order.
            older <= '0;
        end else begin
            valid <= valid_next;
            older <= older_next;
        end
    end

    // Grant registers: load when the issue stage accepts, clear on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_valid <= '0;
            grant_idx   <= '0;
        end else if (flush) begin
            grant_valid <= '0;
            grant_idx   <= '0;
        end else if (!issue_stall) begin
            grant_valid <= grant_valid_next;
            grant_idx   <= grant_idx_next;
        end
    end

    // Allocation legality: target slot must be free.
    for (genvar k = 0; k < ALLOC_W; k++) begin : g_alloc_chk
        a_alloc_free: assert property (@(posedge clk) disable iff (rst)
            alloc_valid[k] |-> !valid[alloc_idx[k]]);
        // Two lanes never target the same slot.
        for (genvar m = k + 1; m < ALLOC_W; m++) begin : g_pair
            a_alloc_distinct: assert property (@(posedge clk) disable iff (rst)
                !(alloc_valid[k] && alloc_valid[m] && (alloc_idx[k] == alloc_idx[m])));
        end
    end

    // Grant sanity: no slot granted twice, valid grants packed from slot 0.
    for (genvar s = 0; s < ISSUE_W; s++) begin : g_grant_chk
        for (genvar t = s + 1; t < ISSUE_W; t++) begin : g_pair
            a_grant_unique: assert property (@(posedge clk) disable iff (rst)
                !(grant_valid[s] && grant_valid[t] && (grant_idx[s] == grant_idx[t])));
        end
        if (s > 0) begin : g_compact
            a_grant_compact: assert property (@(posedge clk) disable iff (rst)
                grant_valid[s] |-> grant_valid[s-1]);
        end
    end

    // A slot is never older than itself.
    for (genvar i = 0; i < N_ENTRY; i++) begin : g_diag_chk
        a_diag_zero: assert property (@(posedge clk) disable iff (rst)
            !older[i][i]);
    end

endmodule

// File: tb/tb_int_age_matrix_picker.sv
// Directed and scoreboarded checks for the integer age-matrix picker.
module tb_int_age_matrix_picker;
    import falco_pkg::*;

    localparam int N  = INT_IQ_SIZE;
    localparam int IW = INT_ISSUE_WIDTH;
    localparam int AW = DISPATCH_WIDTH;
    localparam int XW = INT_IQ_IDX_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [AW-1:0]          alloc_valid;
    logic [AW-1:0][XW-1:0]  alloc_idx;
    logic [N-1:0]           req_ready;
    logic                   issue_stall;
    logic [IW-1:0]          grant_valid;
    logic [IW-1:0][XW-1:0]  grant_idx;

    int total = 0;
    int bad   = 0;

    int_age_matrix_picker #(
        .N_ENTRY (N),
        .ISSUE_W (IW),
        .ALLOC_W (AW),
        .IDX_W   (XW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_idx   (alloc_idx),
        .req_ready   (req_ready),
        .issue_stall (issue_stall),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_alloc();
        alloc_valid = '0;
        alloc_idx   = '0;
    endtask

    task automatic alloc1(input int_iq_idx_t e);
        alloc_valid  = 2'b01;
        alloc_idx[0] = e;
        alloc_idx[1] = '0;
    endtask

    task automatic alloc2(input int_iq_idx_t e0, input int_iq_idx_t e1);
        alloc_valid  = 2'b11;
        alloc_idx[0] = e0;
        alloc_idx[1] = e1;
    endtask

    task automatic check_grants(input string tag, input logic [IW-1:0] gv, input int g0, input int g1);
        check({tag, "_gv"}, 32'(grant_valid), 32'(gv));
        check({tag, "_g0"}, 32'(grant_idx[0]), 32'(g0));
        check({tag, "_g1"}, 32'(grant_idx[1]), 32'(g1));
    endtask

    task automatic check_valid(input string tag, input logic [N-1:0] exp_valid);
        check({tag, "_valid"}, 32'(dut.valid), 32'(exp_valid));
    endtask

    // Reference model for the scoreboard: slots in age order, oldest first.
    int           age_q[$];
    int           keep_q[$];
    int           free_l[$];
    logic [N-1:0] mv;
    logic [IW-1:0] egv;
    int           eg [IW];
    logic [N-1:0] rdy;
    logic         stall;
    int           nal;
    int           ng;
    int           pick;
    int           lane_e [AW];

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        issue_stall = 1'b0;
        req_ready   = '0;
        no_alloc();

        // Reset state.
        #12;
        check_grants("reset", 2'b00, 0, 0);
        check_valid("reset", 8'h00);
        #5 rst = 1'b0;

        // Alloc 3,5 in one cycle with ready already high: not candidates yet.
        alloc2(3'd3, 3'd5);
        req_ready = 8'hFF;
        tick();
        check_grants("s1_alloc", 2'b00, 0, 0);
        check_valid("s1_alloc", 8'h28);
        no_alloc();
        tick();
        check_grants("s1_grant", 2'b11, 3, 5);
        check_valid("s1_grant", 8'h00);
        req_ready = '0;
        tick();
        check_grants("s1_empty", 2'b00, 0, 0);

        // Alloc 7, 2, 0 over three cycles; two grants then the remaining one.
        alloc1(3'd7);
        tick();
        alloc1(3'd2);
        tick();
        alloc1(3'd0);
        tick();
        no_alloc();
        req_ready = 8'hFF;
        tick();
        check_grants("s2_first", 2'b11, 7, 2);
        check_valid("s2_first", 8'h01);
        tick();
        check_grants("s2_second", 2'b01, 0, 0);
        check_valid("s2_second", 8'h00);
        req_ready = '0;
        tick();

        // Stall holds grants and retires nothing, while alloc continues.
        alloc2(3'd1, 3'd6);
        tick();
        alloc1(3'd4);
        tick();
        no_alloc();
        req_ready = 8'hFF;
        tick();
        check_grants("s3_pre", 2'b11, 1, 6);
        check_valid("s3_pre", 8'h10);
        issue_stall = 1'b1;
        alloc1(3'd5);
        tick();
        check_grants("s3_stall1", 2'b11, 1, 6);
        check_valid("s3_stall1", 8'h30);
        no_alloc();
        tick();
        check_grants("s3_stall2", 2'b11, 1, 6);
        check_valid("s3_stall2", 8'h30);
        tick();
        check_grants("s3_stall3", 2'b11, 1, 6);
        check_valid("s3_stall3", 8'h30);
        issue_stall = 1'b0;
        tick();
        check_grants("s3_release", 2'b11, 4, 5);
        check_valid("s3_release", 8'h00);
        req_ready = '0;
        tick();
        check_grants("s3_empty", 2'b00, 0, 0);

        // Flush overrides pending grants, alloc and select.
        alloc2(3'd2, 3'd3);
        tick();
        alloc1(3'd6);
        tick();
        no_alloc();
        req_ready = 8'hFF;
        tick();
        check_grants("s4_pre", 2'b11, 2, 3);
        check_valid("s4_pre", 8'h40);
        flush = 1'b1;
        alloc2(3'd4, 3'd5);
        tick();
        check_grants("s4_flush", 2'b00, 0, 0);
        check_valid("s4_flush", 8'h00);
        flush = 1'b0;
        no_alloc();
        tick();
        check_grants("s4_after", 2'b00, 0, 0);
        check_valid("s4_after", 8'h00);
        req_ready = '0;

        // Free slot 4, reallocate it as youngest behind slot 1.
        alloc1(3'd4);
        tick();
        alloc1(3'd1);
        tick();
        no_alloc();
        req_ready = 8'h10;
        tick();
        check_grants("s5_free4", 2'b01, 4, 0);
        check_valid("s5_free4", 8'h02);
        req_ready = '0;
        tick();
        alloc1(3'd4);
        tick();
        no_alloc();
        req_ready = 8'h12;
        tick();
        check_grants("s5_realloc", 2'b11, 1, 4);
        check_valid("s5_realloc", 8'h00);
        req_ready = '0;
        tick();

        // Full queue: every slot valid, drained oldest-first two at a time.
        alloc2(3'd5, 3'd2);
        tick();
        alloc2(3'd7, 3'd0);
        tick();
        alloc2(3'd3, 3'd6);
        tick();
        alloc2(3'd1, 3'd4);
        tick();
        no_alloc();
        check_valid("s6_full", 8'hFF);
        req_ready = 8'hFF;
        tick();
        check_grants("s6_d0", 2'b11, 5, 2);
        tick();
        check_grants("s6_d1", 2'b11, 7, 0);
        tick();
        check_grants("s6_d2", 2'b11, 3, 6);
        tick();
        check_grants("s6_d3", 2'b11, 1, 4);
        check_valid("s6_drained", 8'h00);
        tick();
        check_grants("s6_empty", 2'b00, 0, 0);
        req_ready = '0;

        // Random traffic against a reference age queue.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        age_q.delete();
        mv  = '0;
        egv = '0;
        for (int s = 0; s < IW; s++) eg[s] = 0;
        for (int c = 0; c < 400; c++) begin
            rdy   = N'($urandom);
            stall = ($urandom_range(0, 7) == 0);
            free_l.delete();
            for (int i = 0; i < N; i++) begin
                if (!mv[i]) free_l.push_back(i);
            end
            nal = $urandom_range(0, AW);
            if (nal > free_l.size()) nal = free_l.size();
            alloc_valid = '0;
            alloc_idx   = '0;
            for (int k = 0; k < nal; k++) begin
                pick        = $urandom_range(0, free_l.size() - 1);
                lane_e[k]   = free_l[pick];
                free_l.delete(pick);
                alloc_valid[k] = 1'b1;
                alloc_idx[k]   = XW'(lane_e[k]);
            end
            req_ready   = rdy;
            issue_stall = stall;

            if (!stall) begin
                egv = '0;
                for (int s = 0; s < IW; s++) eg[s] = 0;
                ng = 0;
                keep_q.delete();
                foreach (age_q[i]) begin
                    if (rdy[age_q[i]] && ng < IW) begin
                        eg[ng]  = age_q[i];
                        egv[ng] = 1'b1;
                        mv[age_q[i]] = 1'b0;
                        ng++;
                    end else begin
                        keep_q.push_back(age_q[i]);
                    end
                end
                age_q = keep_q;
            end
            for (int k = 0; k < nal; k++) begin
                age_q.push_back(lane_e[k]);
                mv[lane_e[k]] = 1'b1;
            end

            tick();
            check("rand_gv", 32'(grant_valid), 32'(egv));
            for (int s = 0; s < IW; s++) begin
                check("rand_gidx", 32'(grant_idx[s]), 32'(eg[s]));
            end
            check("rand_valid", 32'(dut.valid), 32'(mv));
        end

        // Async reset in the middle of traffic clears everything at once.
        alloc_valid = '0;
        free_l.delete();
        for (int i = 0; i < N; i++) begin
            if (!mv[i]) free_l.push_back(i);
        end
        if (free_l.size() > 0) alloc1(XW'(free_l[0]));
        req_ready   = '0;
        issue_stall = 1'b1;
        tick();
        #3 rst = 1'b1;
        #1;
        check_grants("rst_mid", 2'b00, 0, 0);
        check_valid("rst_mid", 8'h00);
        check("rst_mid_older", {31'd0, |dut.older}, 32'd0);
        no_alloc();
        issue_stall = 1'b0;
        #2 rst = 1'b0;
        tick();
        check_grants("rst_after", 2'b00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
